mult_arbiter: RTL
=================

// Module: mult_arbiter
// PURPOSE
// Shares one fixed-point multiplier (two-cycle registered core, Q-format operands)
// between NREQ requesters in the FFT datapath, e.g. the butterfly twiddle-multiply lanes.
// Round-robin grant with a valid/ready handshake. Registers the winning operands into the multiplier.
// Returns each product to its requester through a latency-matched tag pipeline.
// Supports hold/drain so the FFT controller can quiesce the multiplier between stages.
// PARAMETERS
// N        16  operand/product width (bits), matches multiplier N
// NREQ     4   number of requesters, >= 2
// MUL_LAT  2   multiplier latency: cycles from operand on o_mul_* to product on i_mul_p
// PORTS
// i_clk        in   1       clock, all logic on rising edge
// i_rst_n      in   1       asynchronous reset, active low
// i_req_valid  in   NREQ    per-requester operand valid
// o_req_ready  out  NREQ    per-requester grant; at most one bit set
// i_req_a      in   NREQ*N  operand A, requester r at [r*N +: N]
// i_req_b      in   NREQ*N  operand B, same packing
// i_hold       in   1       level: block new grants, let in-flight ops drain
// i_flush      in   1       pulse: discard all in-flight ops
// o_mul_a      out  N       operand A to multiplier (registered)
// o_mul_b      out  N       operand B to multiplier (registered)
// i_mul_p      in   N       product from multiplier
// o_rsp_valid  out  NREQ    one-hot: product for requester r valid this cycle
// o_rsp_data   out  N       product, equals i_mul_p (combinational pass-through)
// o_idle       out  1       FSM in IDLE
// o_issue_cnt  out  16      transfer counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, i_rst_n=0):
//   - ptr=0, FSM=IDLE, tag pipeline cleared.
//   - o_mul_a=o_mul_b=0, o_rsp_valid=0, o_idle=1, o_issue_cnt=0.
// - Arbitration (combinational):
//   - Only when i_hold=0 and i_flush=0.
//   - Grant g = first r with i_req_valid[r]=1, searching ptr, ptr+1, ... mod NREQ.
//   - o_req_ready[g]=1, all others 0.
//   - o_req_ready may depend on i_req_valid; requesters must not gate valid on ready.
// - Transfer = i_req_valid[g] & o_req_ready[g] at a rising edge. On transfer:
//   - o_mul_a<=A[g], o_mul_b<=B[g].
//   - ptr <= (g+1) mod NREQ.
//   - Push tag {1,g} into the tag pipeline.
// - No transfer:
//   - o_mul_a/o_mul_b <= 0.
//   - Push tag {0,x}; ptr holds.
// - Tag pipeline is MUL_LAT+1 stages deep. Entry width is 1 + $clog2(NREQ).
// - Latency: transfer at edge k -> o_rsp_valid[g]=1 during cycle after edge k+1+MUL_LAT.
// - o_rsp_valid is always 0 when the pipeline head is invalid.
// - Throughput: one transfer per cycle. Back-to-back grants to different requesters rotate fairly.
// - A lone requester is granted every cycle.
// - Responses have no backpressure; requesters must accept o_rsp_valid unconditionally.
// - i_flush: clears every tag valid bit on that edge. No o_rsp_valid for dropped ops.
//   - Ready is 0 that cycle, so flush wins over a simultaneous request.
//   - ptr is unchanged.
// - FSM:
//   - IDLE -> RUN on a transfer.
//   - RUN -> DRAIN when i_hold=1.
//   - RUN -> IDLE when the pipeline is empty and there is no transfer.
//   - DRAIN -> IDLE when the pipeline is empty (immediately after a flush).
//   - DRAIN -> RUN if i_hold drops and a transfer occurs.
//   - In IDLE with i_hold=1, no grants are issued.
// - Reset mid-operation aborts all in-flight ops silently.
// CONFIGURATION
// - MULT_ARB_CNT_EN defined:
//   - o_issue_cnt increments by 1 per transfer and saturates at 16'hFFFF.
//   - Cleared only by reset; not cleared by i_flush.
// - MULT_ARB_CNT_EN undefined: o_issue_cnt tied to 16'h0000, no counter logic.
// TESTING (N=16, Q=8, NREQ=4, MUL_LAT=2, real multiplier attached)
// 1. Reset mid-stream -> all outputs at reset values; after release, first grant goes to requester 0.
// 2. Req1 A=0x0180 (1.5), B=0x0200 (2.0) at edge k
//    -> o_rsp_valid=4'b0010, o_rsp_data=0x0300 after edge k+3; other cycles rsp_valid=0.
// 3. All four valid continuously for 8 cycles
//    -> grants 0,1,2,3,0,1,2,3; responses in the same order, 3 cycles later, one per cycle.
// 4. Req2 A=0xFF00 (-1.0), B=0x0280 (2.5) -> o_rsp_valid=4'b0100, o_rsp_data=0xFD80 (-2.5).
// 5. Issue 3 ops, assert i_flush one cycle later
//    -> no o_rsp_valid for any of them; o_idle=1 next cycle; requests after flush complete normally.
// 6. i_hold=1 with 2 ops in flight and all requesters valid
//    -> ready stays 0; both responses arrive; FSM DRAIN->IDLE.
//    Release hold -> grant resumes at saved ptr. With MULT_ARB_CNT_EN, o_issue_cnt = total transfers.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// Bundle between the FFT lanes / shared multiplier and mult_arbiter.
// slave  : arbiter side (takes requests and products, drives grants,
//          operands and responses).
// master : environment side (requesters, multiplier core, controller).
// Signals:
//   i_req_valid/o_req_ready   per-requester handshake (NREQ bits)
//   i_req_a/i_req_b           packed operands, requester r at [r*N +: N]
//   i_hold/i_flush            controller quiesce / discard
//   o_mul_a/o_mul_b/i_mul_p   multiplier operands and product
//   o_rsp_valid/o_rsp_data    one-hot product return
//   o_idle/o_issue_cnt        status
interface mult_arbiter_if #(
  parameter int unsigned N    = 16,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   i_req_valid;
  logic [NREQ-1:0]   o_req_ready;
  logic [NREQ*N-1:0] i_req_a;
  logic [NREQ*N-1:0] i_req_b;
  logic              i_hold;
  logic              i_flush;
  logic [N-1:0]      o_mul_a;
  logic [N-1:0]      o_mul_b;
  logic [N-1:0]      i_mul_p;
  logic [NREQ-1:0]   o_rsp_valid;
  logic [N-1:0]      o_rsp_data;
  logic              o_idle;
  logic [15:0]       o_issue_cnt;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_hold, i_flush, i_mul_p,
    output o_req_ready, o_mul_a, o_mul_b, o_rsp_valid, o_rsp_data, o_idle, o_issue_cnt
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_hold, i_flush, i_mul_p,
    input  o_req_ready, o_mul_a, o_mul_b, o_rsp_valid, o_rsp_data, o_idle, o_issue_cnt
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point multiplier between NREQ
// requesters. The winning operands are registered onto o_mul_*, and a tag rides
// alongside through a latency-matched pipeline so each product returns one-hot
// on o_rsp_valid together with the multiplier output on o_rsp_data.
// i_hold blocks new grants while in-flight work drains; i_flush drops it all.
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous reset, active low
//   bus       mult_arbiter_if.slave (requests, multiplier, responses, status)
// Build option: define MULT_ARB_CNT_EN for a saturating transfer counter on
// o_issue_cnt; otherwise o_issue_cnt is tied to zero.
module mult_arbiter #(
  parameter int unsigned N       = 16,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input logic           i_clk,
  input logic           i_rst_n,
  mult_arbiter_if.slave bus
);
  localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW    = 1 + IW;
  localparam int unsigned DEPTH = MUL_LAT + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  // Tag aligned with o_mul_*; the pipeline then covers the multiplier's sampling
  // edge plus its MUL_LAT stages, so the head lines up with i_mul_p.
  logic [TW-1:0] issue_tag_q, issue_tag_d;
  logic [TW-1:0] tag_q [DEPTH];
  logic [TW-1:0] tag_d [DEPTH];

  logic [NREQ-1:0] ready;
  logic [IW-1:0]   gnt_idx;
  logic            found;
  logic            xfer;
  logic            pipe_busy;
  logic            pipe_empty;
  logic [IW:0]     sum;
  logic [TW-1:0]   head;
  logic [NREQ-1:0] rsp_valid;

  // Rotating search starting at ptr; grants suppressed under hold or flush.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    ready   = '0;
    sum     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + (IW + 1)'(i);
      if (sum >= (IW + 1)'(NREQ)) sum = sum - (IW + 1)'(NREQ);
      if (!found && bus.i_req_valid[sum[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[IW-1:0];
      end
    end
    if (found && !bus.i_hold && !bus.i_flush) ready[gnt_idx] = 1'b1;
  end

  assign xfer = |(bus.i_req_valid & ready);

  always_comb begin
    pipe_busy = issue_tag_q[TW-1];
    for (int unsigned i = 0; i < DEPTH; i++) pipe_busy = pipe_busy | tag_q[i][TW-1];
  end

  // A flush empties the pipeline on this very edge.
  assign pipe_empty = bus.i_flush | ~pipe_busy;

  always_comb begin
    ptr_d       = ptr_q;
    mul_a_d     = '0;
    mul_b_d     = '0;
    issue_tag_d = '0;
    if (xfer) begin
      ptr_d       = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      mul_a_d     = bus.i_req_a[32'(gnt_idx) * N +: N];
      mul_b_d     = bus.i_req_b[32'(gnt_idx) * N +: N];
      issue_tag_d = {1'b1, gnt_idx};
    end
    tag_d[0] = issue_tag_q;
    for (int unsigned i = 1; i < DEPTH; i++) tag_d[i] = tag_q[i-1];
    if (bus.i_flush) begin
      issue_tag_d[TW-1] = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_d[i][TW-1] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (xfer) state_d = StRun;
      StRun: begin
        if (bus.i_hold)             state_d = StDrain;
        else if (pipe_empty && !xfer) state_d = StIdle;
      end
      StDrain: begin
        if (xfer)            state_d = StRun;
        else if (pipe_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      issue_tag_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      issue_tag_q <= issue_tag_d;
      for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign head = tag_q[DEPTH-1];

  always_comb begin
    rsp_valid = '0;
    if (head[TW-1]) rsp_valid[head[IW-1:0]] = 1'b1;
  end

`ifdef MULT_ARB_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.o_issue_cnt = cnt_q;
`else
  assign bus.o_issue_cnt = 16'h0000;
`endif

  assign bus.o_req_ready = ready;
  assign bus.o_mul_a     = mul_a_q;
  assign bus.o_mul_b     = mul_b_q;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_data  = bus.i_mul_p;
  assign bus.o_idle      = (state_q == StIdle);
endmodule
